// File: rtl/rv_pkg.sv
// Shared encodings for the multi-cycle RV control unit: FSM states, the
// opcodes it dispatches on, and the datapath mux/ALU select codes.
package rv_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_EXEC_I = 4'd3,
    ST_ADDR   = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_MEM_WR = 4'd6,
    ST_WB_ALU = 4'd7,
    ST_WB_MEM = 4'd8,
    ST_BRANCH = 4'd9,
    ST_TRAP   = 4'd10
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_R   = 2'b01;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

endpackage

// File: rtl/mc_ctrl.sv
// Multi-cycle instruction control FSM: sequences fetch/decode/execute/memory/
// write-back, drives datapath selects and counts retired instructions.
module mc_ctrl
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        trap,
  output logic [31:0] instret
);

  state_e      r_state;
  state_e      w_next;
  logic        w_retire;
  logic [31:0] r_instret;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Counter is only written on reset or retire so it holds otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = ADDR_PC;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RS2;
    alu_op    = ALU_OP_ADD;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    trap      = 1'b0;

    unique case (r_state)
      ST_FETCH: begin
        mem_req = 1'b1;
        // PC+4 is computed and written in the same cycle the word arrives
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
          w_next    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_R:               w_next = ST_EXEC_R;
          OP_I:               w_next = ST_EXEC_I;
          OP_LOAD, OP_STORE:  w_next = ST_ADDR;
          OP_BRANCH:          w_next = ST_BRANCH;
          default:            w_next = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_R;
        w_next    = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = ST_WB_ALU;
      end
      ST_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_ALU;
        if (mem_ready) w_next = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = ADDR_ALU;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end
      end
      ST_WB_ALU: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = 1'b1;
        w_retire  = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_BRANCH: begin
        pc_write = br_taken;
        pc_sel   = 1'b1;
        w_retire = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        w_next = ST_FETCH;
      end
    endcase
  end

  assign instret = r_instret;

endmodule
